// File: rtl/dualtimer_sched_pkg.sv
// Shared definitions for the dual-timer scheduler: register map, Control bit
// positions, FSM/operation encodings and the APB beat generator.
package dualtimer_sched_pkg;

    localparam logic [11:0] OFF_LOAD   = 12'h000;
    localparam logic [11:0] OFF_CTRL   = 12'h008;
    localparam logic [11:0] OFF_INTCLR = 12'h00C;
    localparam logic [11:0] BASE_T1    = 12'h000;
    localparam logic [11:0] BASE_T2    = 12'h020;

    localparam int CTRL_ONESHOT  = 0;
    localparam int CTRL_SIZE32   = 1;
    localparam int CTRL_PRE_LSB  = 2;
    localparam int CTRL_INTEN    = 5;
    localparam int CTRL_PERIODIC = 6;
    localparam int CTRL_EN       = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_FIN    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_START  = 2'd0,
        OP_STOP   = 2'd1,
        OP_INTCLR = 2'd2
    } op_t;

    typedef struct packed {
        logic [11:2] addr;
        logic [31:0] data;
    } beat_t;

    function automatic logic [31:0] ctrl_start(input logic oneshot, input logic [1:0] pre);
        logic [31:0] v;
        v = '0;
        v[CTRL_EN]                  = 1'b1;
        v[CTRL_INTEN]               = 1'b1;
        v[CTRL_SIZE32]              = 1'b1;
        v[CTRL_ONESHOT]             = oneshot;
        v[CTRL_PERIODIC]            = ~oneshot;
        v[CTRL_PRE_LSB +: 2]        = pre;
        return v;
    endfunction

    // Address/data of write number 'step' within operation 'op'.
    function automatic beat_t make_beat(input op_t op, input logic [1:0] step, input logic ch,
                                        input logic [31:0] load, input logic oneshot,
                                        input logic [1:0] pre);
        logic [11:2] base_w;
        beat_t       b;
        base_w = ch ? BASE_T2[11:2] : BASE_T1[11:2];
        b.addr = base_w + OFF_CTRL[11:2];
        b.data = '0;
        case (op)
            OP_INTCLR: begin
                b.addr = base_w + OFF_INTCLR[11:2];
                b.data = 32'd1;
            end
            OP_START: begin
                if (step == 2'd1) begin
                    b.addr = base_w + OFF_LOAD[11:2];
                    b.data = load;
                end else if (step == 2'd2) begin
                    b.data = ctrl_start(oneshot, pre);
                end
            end
            default: ;
        endcase
        return b;
    endfunction

    function automatic logic [1:0] last_step(input op_t op);
        return (op == OP_START) ? 2'd2 : 2'd0;
    endfunction

endpackage

// File: rtl/dualtimer_sched_rr_arb.sv
// Round-robin arbiter: searches from the requester after the last accepted
// grantee; the pointer only moves when the scheduler accepts the grant.
module dualtimer_sched_rr_arb #(
    parameter int NREQ = 4
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          eligible,
    input  logic                     accept,
    output logic [NREQ-1:0]          grant,
    output logic [$clog2(NREQ)-1:0]  grant_idx
);
    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] ptr_reg;
    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            sum = {1'b0, ptr_reg} + (IW+1)'(k);
            if (sum >= (IW+1)'(NREQ))
                sum = sum - (IW+1)'(NREQ);
            idx = sum[IW-1:0];
            if (!found && req[idx] && eligible[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET)
            ptr_reg <= '0;
        else if (accept && found)
            ptr_reg <= grant_idx;
    end

endmodule

// File: rtl/dualtimer_sched.sv
// APB master that serialises start/stop/interrupt-clear sequences for a dual
// timer on behalf of NREQ requesters. Optional: DUALTIMER_SCHED_PRESCALE_EN.
module dualtimer_sched
    import dualtimer_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic [NREQ-1:0]     req,
    output logic [NREQ-1:0]     ack,
    input  logic [NREQ-1:0]     req_ch,
    input  logic [NREQ-1:0]     req_oneshot,
    input  logic [NREQ*32-1:0]  req_load,
`ifdef DUALTIMER_SCHED_PRESCALE_EN
    input  logic [NREQ*2-1:0]   req_pre,
`endif
    output logic [NREQ-1:0]     done,
    output logic [1:0]          busy_ch,
    output logic                PSEL,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [11:2]         PADDR,
    output logic [31:0]         PWDATA,
    input  logic                TIMINT1,
    input  logic                TIMINT2
);
    localparam int IW = $clog2(NREQ);

    state_t        state_reg, state_next;
    op_t           op_reg, op_next;
    logic [1:0]    step_reg, step_next;
    logic [IW-1:0] idx_reg, idx_next;
    logic          ch_reg, ch_next;
    logic          oneshot_reg, oneshot_next;
    logic [31:0]   load_reg, load_next;
    logic [1:0]    pre_reg, pre_next;
    logic          done_en_reg, done_en_next;
    logic [1:0]    busy_reg, busy_next;
    logic [IW-1:0] owner_reg [2];
    logic [IW-1:0] owner_next [2];
    logic [1:0]    ch_oneshot_reg, ch_oneshot_next;
    logic [1:0]    pend_reg, pend_next, pend_clr;
    logic [1:0]    timint_prev_reg;
    logic [11:2]   paddr_reg, paddr_next;
    logic [31:0]   pwdata_reg, pwdata_next;

    logic [NREQ-1:0] eligible, grant;
    logic [IW-1:0]   grant_idx;
    logic            accept, load_beat;
    logic [1:0]      pre_sel, timint;
    logic [31:0]     load_arr [NREQ];
    beat_t           beat_w;

    genvar gi;
    for (gi = 0; gi < NREQ; gi++) begin : g_req
        assign load_arr[gi] = req_load[gi*32 +: 32];
        // A requester may use a free channel or one it already owns.
        assign eligible[gi] = !busy_reg[req_ch[gi]] || (owner_reg[req_ch[gi]] == IW'(gi));
        assign ack[gi]  = (state_reg == ST_FIN) && (op_reg != OP_INTCLR) && (idx_reg == IW'(gi));
        assign done[gi] = (state_reg == ST_FIN) && (op_reg == OP_INTCLR) && done_en_reg
                          && (idx_reg == IW'(gi));
    end

`ifdef DUALTIMER_SCHED_PRESCALE_EN
    logic [1:0] pre_arr [NREQ];
    for (gi = 0; gi < NREQ; gi++) begin : g_pre
        assign pre_arr[gi] = req_pre[gi*2 +: 2];
    end
    assign pre_sel = pre_arr[grant_idx];
`else
    assign pre_sel = 2'b00;
`endif

    dualtimer_sched_rr_arb #(.NREQ(NREQ)) u_arb (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req       (req),
        .eligible  (eligible),
        .accept    (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign timint  = {TIMINT2, TIMINT1};
    assign PSEL    = (state_reg == ST_SETUP) || (state_reg == ST_ACCESS);
    assign PENABLE = (state_reg == ST_ACCESS);
    assign PWRITE  = 1'b1;
    assign PADDR   = paddr_reg;
    assign PWDATA  = pwdata_reg;
    assign busy_ch = busy_reg;

    always_comb begin
        state_next      = state_reg;
        op_next         = op_reg;
        step_next       = step_reg;
        idx_next        = idx_reg;
        ch_next         = ch_reg;
        oneshot_next    = oneshot_reg;
        load_next       = load_reg;
        pre_next        = pre_reg;
        done_en_next    = done_en_reg;
        busy_next       = busy_reg;
        owner_next      = owner_reg;
        ch_oneshot_next = ch_oneshot_reg;
        paddr_next      = paddr_reg;
        pwdata_next     = pwdata_reg;
        pend_clr        = 2'b00;
        accept          = 1'b0;
        load_beat       = 1'b0;
        beat_w          = '0;
        case (state_reg)
            ST_IDLE: begin
                // Interrupt service outranks requests; Timer1 outranks Timer2.
                if (pend_reg != 2'b00) begin
                    ch_next           = ~pend_reg[0];
                    pend_clr[ch_next] = 1'b1;
                    op_next           = OP_INTCLR;
                    done_en_next      = busy_reg[ch_next];
                    idx_next          = owner_reg[ch_next];
                    step_next         = 2'd0;
                    state_next        = ST_SETUP;
                    load_beat         = 1'b1;
                end else if (grant != '0) begin
                    accept       = 1'b1;
                    idx_next     = grant_idx;
                    ch_next      = req_ch[grant_idx];
                    oneshot_next = req_oneshot[grant_idx];
                    load_next    = load_arr[grant_idx];
                    pre_next     = pre_sel;
                    op_next      = (load_next == 32'd0) ? OP_STOP : OP_START;
                    if (op_next == OP_START) begin
                        busy_next[ch_next]       = 1'b1;
                        owner_next[ch_next]      = grant_idx;
                        ch_oneshot_next[ch_next] = oneshot_next;
                    end
                    step_next  = 2'd0;
                    state_next = ST_SETUP;
                    load_beat  = 1'b1;
                end
            end
            ST_SETUP: state_next = ST_ACCESS;
            ST_ACCESS: begin
                if (step_reg == last_step(op_reg)) begin
                    state_next = ST_FIN;
                end else begin
                    step_next  = step_reg + 2'd1;
                    state_next = ST_SETUP;
                    load_beat  = 1'b1;
                end
            end
            ST_FIN: begin
                state_next = ST_IDLE;
                if (op_reg == OP_STOP)
                    busy_next[ch_reg] = 1'b0;
                else if (op_reg == OP_INTCLR && done_en_reg && ch_oneshot_reg[ch_reg])
                    busy_next[ch_reg] = 1'b0;
            end
            default: state_next = ST_IDLE;
        endcase
        if (load_beat) begin
            beat_w      = make_beat(op_next, step_next, ch_next, load_next, oneshot_next, pre_next);
            paddr_next  = beat_w.addr;
            pwdata_next = beat_w.data;
        end
        // A repeat edge while the flag is still set simply merges into it.
        pend_next = (pend_reg & ~pend_clr) | (timint & ~timint_prev_reg);
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_reg       <= ST_IDLE;
            op_reg          <= OP_START;
            step_reg        <= '0;
            idx_reg         <= '0;
            ch_reg          <= 1'b0;
            oneshot_reg     <= 1'b0;
            load_reg        <= '0;
            pre_reg         <= '0;
            done_en_reg     <= 1'b0;
            busy_reg        <= '0;
            owner_reg       <= '{default: '0};
            ch_oneshot_reg  <= '0;
            pend_reg        <= '0;
            timint_prev_reg <= '0;
            paddr_reg       <= '0;
            pwdata_reg      <= '0;
        end else begin
            state_reg       <= state_next;
            op_reg          <= op_next;
            step_reg        <= step_next;
            idx_reg         <= idx_next;
            ch_reg          <= ch_next;
            oneshot_reg     <= oneshot_next;
            load_reg        <= load_next;
            pre_reg         <= pre_next;
            done_en_reg     <= done_en_next;
            busy_reg        <= busy_next;
            owner_reg       <= owner_next;
            ch_oneshot_reg  <= ch_oneshot_next;
            pend_reg        <= pend_next;
            timint_prev_reg <= timint;
            paddr_reg       <= paddr_next;
            pwdata_reg      <= pwdata_next;
        end
    end

endmodule
